// File: rtl/alu_seq.sv
// alu_seq: parameterised ALU with valid/ready issue, status flags and an
// iterative restoring divider for the divide/modulo opcodes.
//
// state | meaning
// IDLE  | accepting ops; single-cycle ops complete on their accept edge
// DIV   | restoring divider running, one quotient bit per cycle, issue stalled
// DONE  | sign correction; result and flags registered on the way to IDLE
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] res,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_dz
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_MUL   = 5'h02;
    localparam logic [4:0] OP_OR    = 5'h03;
    localparam logic [4:0] OP_XOR   = 5'h04;
    localparam logic [4:0] OP_AND   = 5'h05;
    localparam logic [4:0] OP_SRA   = 5'h06;
    localparam logic [4:0] OP_SRL   = 5'h07;
    localparam logic [4:0] OP_SLL   = 5'h08;
    localparam logic [4:0] OP_NEG   = 5'h09;
    localparam logic [4:0] OP_LNOT  = 5'h0A;
    localparam logic [4:0] OP_NOT   = 5'h0B;
    localparam logic [4:0] OP_NZ    = 5'h0C;
    localparam logic [4:0] OP_EQ    = 5'h0D;
    localparam logic [4:0] OP_NE    = 5'h0E;
    localparam logic [4:0] OP_SLT   = 5'h0F;
    localparam logic [4:0] OP_ULT   = 5'h10;
    localparam logic [4:0] OP_SLE   = 5'h11;
    localparam logic [4:0] OP_ULE   = 5'h12;
    localparam logic [4:0] OP_SEXT  = 5'h13;
    localparam logic [4:0] OP_PASSB = 5'h14;
    localparam logic [4:0] OP_DIVU  = 5'h15;
    localparam logic [4:0] OP_MODU  = 5'h16;
    localparam logic [4:0] OP_DIVS  = 5'h17;
    localparam logic [4:0] OP_MODS  = 5'h18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_dz_q, flag_dz_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mod_q, mod_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_dz;
    logic [WIDTH:0]   sum_ext;
    logic [SHW-1:0]   shamt;

    logic             is_div;
    logic             is_sdiv;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] div_res;

    // Result of every op that completes on its accept edge, incl. divide by zero.
    always_comb begin
        sc_res  = a;
        sc_c    = 1'b0;
        sc_dz   = 1'b0;
        sum_ext = {1'b0, b} + {1'b0, a};
        shamt   = a[SHW-1:0];
        case (op)
            OP_ADD:   begin sc_res = sum_ext[WIDTH-1:0]; sc_c = sum_ext[WIDTH]; end
            OP_SUB:   begin sc_res = b - a; sc_c = (b < a); end
            OP_MUL:   sc_res = b * a;
            OP_OR:    sc_res = b | a;
            OP_XOR:   sc_res = b ^ a;
            OP_AND:   sc_res = b & a;
            OP_SRA:   sc_res = $signed(b) >>> shamt;
            OP_SRL:   sc_res = b >> shamt;
            OP_SLL:   sc_res = b << shamt;
            OP_NEG:   sc_res = '0 - a;
            OP_LNOT:  sc_res = {{(WIDTH-1){1'b0}}, a == '0};
            OP_NOT:   sc_res = ~a;
            OP_NZ:    sc_res = {{(WIDTH-1){1'b0}}, a != '0};
            OP_EQ:    sc_res = {{(WIDTH-1){1'b0}}, b == a};
            OP_NE:    sc_res = {{(WIDTH-1){1'b0}}, b != a};
            OP_SLT:   sc_res = {{(WIDTH-1){1'b0}}, $signed(b) < $signed(a)};
            OP_ULT:   sc_res = {{(WIDTH-1){1'b0}}, b < a};
            OP_SLE:   sc_res = {{(WIDTH-1){1'b0}}, $signed(b) <= $signed(a)};
            OP_ULE:   sc_res = {{(WIDTH-1){1'b0}}, b <= a};
            OP_SEXT:  sc_res = {{(WIDTH/2){a[WIDTH/2-1]}}, a[WIDTH/2-1:0]};
            OP_PASSB: sc_res = b;
            // Divide ops only complete here when the divisor is zero.
            OP_DIVU, OP_DIVS: begin sc_res = '1; sc_dz = 1'b1; end
            OP_MODU, OP_MODS: begin sc_res = b;  sc_dz = 1'b1; end
            default:  sc_res = a;
        endcase
    end

    // Divider datapath: operand magnitudes, one restoring step, final sign fix.
    always_comb begin
        is_div   = (op == OP_DIVU) || (op == OP_MODU) || (op == OP_DIVS) || (op == OP_MODS);
        is_sdiv  = (op == OP_DIVS) || (op == OP_MODS);
        a_mag    = (is_sdiv && a[WIDTH-1]) ? ('0 - a) : a;
        b_mag    = (is_sdiv && b[WIDTH-1]) ? ('0 - b) : b;
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        rem_sub  = rem_sh - {1'b0, dvs_q};
        q_bit    = ~rem_sub[WIDTH];
        rem_next = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        if (mod_q) begin
            div_res = neg_rem_q ? ('0 - rem_q) : rem_q;
        end else begin
            div_res = neg_quo_q ? ('0 - quo_q) : quo_q;
        end
    end

    // Issue control, divider sequencing and completion of results/flags.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = 1'b0;
        res_d       = res_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        flag_c_d    = flag_c_q;
        flag_dz_d   = flag_dz_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        mod_d       = mod_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (is_div && (a != '0)) begin
                        state_d    = S_DIV;
                        in_ready_d = 1'b0;
                        rem_d      = '0;
                        quo_d      = b_mag;
                        dvs_d      = a_mag;
                        cnt_d      = CW'(WIDTH);
                        mod_d      = (op == OP_MODU) || (op == OP_MODS);
                        neg_quo_d  = is_sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d  = is_sdiv && b[WIDTH-1];
                    end else begin
                        res_d       = sc_res;
                        flag_z_d    = (sc_res == '0);
                        flag_n_d    = sc_res[WIDTH-1];
                        flag_c_d    = sc_c;
                        flag_dz_d   = sc_dz;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_DIV: begin
                rem_d = rem_next;
                quo_d = {quo_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                res_d       = div_res;
                flag_z_d    = (div_res == '0);
                flag_n_d    = div_res[WIDTH-1];
                flag_c_d    = 1'b0;
                flag_dz_d   = 1'b0;
                out_valid_d = 1'b1;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State register; reset aborts any divide in flight without a result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_dz_q   <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            mod_q       <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_c_q    <= flag_c_d;
            flag_dz_q   <= flag_dz_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            mod_q       <= mod_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_c    = flag_c_q;
    assign flag_dz   = flag_dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=16: directed scenarios plus randomized ops
// checked against an integer-arithmetic reference model.
module tb_alu_seq;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [4:0]    op;
    logic          out_valid;
    logic [W-1:0]  res;
    logic          flag_z;
    logic          flag_n;
    logic          flag_c;
    logic          flag_dz;

    int tests = 0;
    int fails = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .res(res),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_dz(flag_dz)
    );

    always #5 clk = ~clk;

    // Reference model: plain 32-bit integer arithmetic, truncated to 16 bits.
    // lat is the number of clock edges from the accept edge to the edge that
    // raises out_valid (0 for single-cycle ops).
    function automatic void model(input logic [4:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [W-1:0] r, output logic c, output logic dz, output int lat);
        int unsigned ua, ub, t, sh;
        int sa, sb;
        ua = {16'd0, av};
        ub = {16'd0, bv};
        sa = int'($signed(av));
        sb = int'($signed(bv));
        sh = ua % 16;
        c = 1'b0; dz = 1'b0; lat = 0; t = ua;
        case (o)
            5'h00: begin t = ub + ua; c = (t > 32'h0000FFFF); end
            5'h01: begin t = ub - ua; c = (ub < ua); end
            5'h02: t = ub * ua;
            5'h03: t = ub | ua;
            5'h04: t = ub ^ ua;
            5'h05: t = ub & ua;
            5'h06: t = int'(sb >>> sh);
            5'h07: t = ub >> sh;
            5'h08: t = ub << sh;
            5'h09: t = int'(-sa);
            5'h0A: t = (ua == 0) ? 1 : 0;
            5'h0B: t = ~ua;
            5'h0C: t = (ua != 0) ? 1 : 0;
            5'h0D: t = (ub == ua) ? 1 : 0;
            5'h0E: t = (ub != ua) ? 1 : 0;
            5'h0F: t = (sb < sa) ? 1 : 0;
            5'h10: t = (ub < ua) ? 1 : 0;
            5'h11: t = (sb <= sa) ? 1 : 0;
            5'h12: t = (ub <= ua) ? 1 : 0;
            5'h13: t = ((ua & 255) ^ 128) - 128;
            5'h14: t = ub;
            5'h15: if (ua == 0) begin t = 32'hFFFF; dz = 1'b1; end else begin t = ub / ua; lat = W + 1; end
            5'h16: if (ua == 0) begin t = ub; dz = 1'b1; end else begin t = ub % ua; lat = W + 1; end
            5'h17: if (ua == 0) begin t = 32'hFFFF; dz = 1'b1; end else begin t = int'(sb / sa); lat = W + 1; end
            5'h18: if (ua == 0) begin t = ub; dz = 1'b1; end else begin t = int'(sb % sa); lat = W + 1; end
            default: t = ua;
        endcase
        r = t[15:0];
    endfunction

    // Issue one op, wait (bounded) for its result. edges = -1 on timeout.
    // lowc counts sampled cycles with in_ready low while waiting.
    task automatic do_op(input logic [4:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] r, output logic [3:0] fl, output int edges, output int lowc);
        int n;
        op = o; a = av; b = bv; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0; lowc = 0;
        while (!out_valid && edges < 100) begin
            if (!in_ready) lowc++;
            @(posedge clk); #1;
            edges++;
        end
        if (!out_valid) edges = -1;
        r  = res;
        fl = {flag_z, flag_n, flag_c, flag_dz};
    endtask

    task automatic test_reset();
        logic [W-1:0] r; logic [3:0] fl; int e, lc;
        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (res !== 16'h0000) begin fails++; $display("FAIL reset_res got %h want 0000", res); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if ({flag_z, flag_n, flag_c, flag_dz} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {flag_z, flag_n, flag_c, flag_dz}); end
        rst = 1'b1;
        @(posedge clk); #1;
        do_op(5'h00, 16'h0001, 16'hFFFF, r, fl, e, lc);
        tests++; if (e !== 0) begin fails++; $display("FAIL add_latency got %0d want 0", e); end
        tests++; if (r !== 16'h0000) begin fails++; $display("FAIL add_wrap_res got %h want 0000", r); end
        tests++; if (fl !== 4'b1010) begin fails++; $display("FAIL add_wrap_flags(z,n,c,dz) got %b want 1010", fl); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]   ops [3] = '{5'h01, 5'h06, 5'h13};
        logic [W-1:0] av  [3] = '{16'h0007, 16'h0013, 16'h0080};
        logic [W-1:0] bv  [3] = '{16'h0005, 16'h8000, 16'h1234};
        logic [W-1:0] er  [3] = '{16'hFFFE, 16'hF000, 16'hFF80};
        logic [1:0]   ecn [3] = '{2'b11, 2'b01, 2'b01};
        for (int i = 0; i < 3; i++) begin
            op = ops[i]; a = av[i]; b = bv[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b1 || res !== er[i]) begin
                fails++; $display("FAIL b2b_%0d got v=%b res=%h want v=1 res=%h", i, out_valid, res, er[i]); end
            tests++; if ({flag_c, flag_n} !== ecn[i]) begin
                fails++; $display("FAIL b2b_flags_%0d got c,n=%b want %b", i, {flag_c, flag_n}, ecn[i]); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end got v=%b want 0", out_valid); end
    endtask

    task automatic test_udiv();
        logic [W-1:0] r; logic [3:0] fl; int e, lc;
        do_op(5'h15, 16'd7, 16'd1000, r, fl, e, lc);
        tests++; if (e !== W + 1) begin fails++; $display("FAIL udiv_latency got %0d want %0d", e, W + 1); end
        tests++; if (lc !== W + 1) begin fails++; $display("FAIL udiv_stall got %0d low cycles want %0d", lc, W + 1); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL udiv_ready_at_done got %b want 1", in_ready); end
        tests++; if (r !== 16'd142) begin fails++; $display("FAIL udiv_res got %0d want 142", r); end
        do_op(5'h16, 16'd7, 16'd1000, r, fl, e, lc);
        tests++; if (r !== 16'd6) begin fails++; $display("FAIL umod_res got %0d want 6", r); end
    endtask

    task automatic test_sdiv();
        logic [W-1:0] r; logic [3:0] fl; int e, lc;
        do_op(5'h17, 16'd2, 16'hFFF9, r, fl, e, lc);
        tests++; if (r !== 16'hFFFD || fl !== 4'b0100) begin
            fails++; $display("FAIL sdiv_res got %h flags %b want FFFD flags 0100", r, fl); end
        do_op(5'h18, 16'd2, 16'hFFF9, r, fl, e, lc);
        tests++; if (r !== 16'hFFFF) begin fails++; $display("FAIL smod_res got %h want FFFF", r); end
        do_op(5'h17, 16'hFFFF, 16'h8000, r, fl, e, lc);
        tests++; if (r !== 16'h8000 || fl[0] !== 1'b0) begin
            fails++; $display("FAIL sdiv_ovf got %h dz=%b want 8000 dz=0", r, fl[0]); end
        do_op(5'h18, 16'hFFFF, 16'h8000, r, fl, e, lc);
        tests++; if (r !== 16'h0000 || fl !== 4'b1000) begin
            fails++; $display("FAIL smod_ovf got %h flags %b want 0000 flags 1000", r, fl); end
    endtask

    task automatic test_divzero();
        logic [W-1:0] r; logic [3:0] fl; int e, lc;
        do_op(5'h15, 16'h0000, 16'h1234, r, fl, e, lc);
        tests++; if (e !== 0) begin fails++; $display("FAIL dz_latency got %0d want 0", e); end
        tests++; if (r !== 16'hFFFF || fl[0] !== 1'b1) begin
            fails++; $display("FAIL dz_div got %h dz=%b want FFFF dz=1", r, fl[0]); end
        do_op(5'h16, 16'h0000, 16'h1234, r, fl, e, lc);
        tests++; if (r !== 16'h1234 || fl[0] !== 1'b1) begin
            fails++; $display("FAIL dz_mod got %h dz=%b want 1234 dz=1", r, fl[0]); end
    endtask

    task automatic test_abort();
        int seen;
        op = 5'h15; a = 16'd7; b = 16'd1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL abort_busy got in_ready=%b want 0", in_ready); end
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 16'h0000) begin
            fails++; $display("FAIL abort_reset got rdy=%b v=%b res=%h want 1 0 0000", in_ready, out_valid, res); end
        tests++; if ({flag_z, flag_n, flag_c, flag_dz} !== 4'b0000) begin
            fails++; $display("FAIL abort_flags got %b want 0000", {flag_z, flag_n, flag_c, flag_dz}); end
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        tests++; if (seen !== 0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL abort_no_result got %0d pulses rdy=%b want 0 pulses rdy=1", seen, in_ready); end
    endtask

    task automatic test_stall();
        int e;
        bit leaked;
        op = 5'h15; a = 16'd7; b = 16'd1000; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 5'h00; a = 16'd4; b = 16'd3;
        e = 0; leaked = 1'b0;
        while (!out_valid && e < 100) begin
            if (in_ready) leaked = 1'b1;
            @(posedge clk); #1;
            e++;
        end
        tests++; if (e !== W + 1 || res !== 16'd142) begin
            fails++; $display("FAIL stall_div got lat=%0d res=%0d want %0d and 142", e, res, W + 1); end
        tests++; if (leaked !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL stall_ready got early=%b rdy_at_done=%b want 0 1", leaked, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || res !== 16'd7) begin
            fails++; $display("FAIL stall_held_op got v=%b res=%0d want v=1 res=7", out_valid, res); end
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_single got v=%b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic [W-1:0] r, er, av, bv; logic [3:0] fl; logic ec, edz; int e, lc, elat;
        logic [4:0] o;
        for (int i = 0; i < 150; i++) begin
            o  = 5'($urandom_range(0, 31));
            av = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            bv = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
            if ($urandom_range(0, 7) == 0) av = 16'hFFFF;
            model(o, av, bv, er, ec, edz, elat);
            do_op(o, av, bv, r, fl, e, lc);
            tests++; if (r !== er || e !== elat) begin
                fails++; $display("FAIL rand_op%h a=%h b=%h got res=%h lat=%0d want res=%h lat=%0d",
                                  o, av, bv, r, e, er, elat); end
            tests++; if (fl !== {er == 16'h0000, er[15], ec, edz}) begin
                fails++; $display("FAIL rand_flags_op%h a=%h b=%h got %b want %b",
                                  o, av, bv, fl, {er == 16'h0000, er[15], ec, edz}); end
        end
        // Continuous single-cycle stream: one result per cycle.
        for (int i = 0; i < 40; i++) begin
            o = 5'($urandom_range(0, 31));
            av = 16'($urandom);
            bv = 16'($urandom);
            if (o >= 5'h15 && o <= 5'h18) av = 16'h0000;
            op = o; a = av; b = bv; in_valid = 1'b1;
            model(o, av, bv, er, ec, edz, elat);
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b1 || res !== er || {flag_c, flag_dz} !== {ec, edz}) begin
                fails++; $display("FAIL stream_op%h a=%h b=%h got v=%b res=%h c,dz=%b want 1 %h %b",
                                  o, av, bv, out_valid, res, {flag_c, flag_dz}, er, {ec, edz}); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_udiv();
        test_sdiv();
        test_divzero();
        test_abort();
        test_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
